issue_stage_unit: RTL and testbench

- Superscalar issue stage of the out-of-order RISC-V core; sits between the reservation station and the execute stage.
- Each cycle it accepts up to N_WAY ready instructions (tags only) from the RS.
- Reads source operands from the physical register file it owns, which writeback updates.
- Registers one ISSUE_EX_PACKET per way for execute.

---
 rtl/issue_stage_unit_pkg.sv | 71 +++++++
 rtl/issue_stage_unit_regfile.sv | 42 ++++
 rtl/issue_stage_unit.sv | 71 +++++++
 tb/tb_issue_stage_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_stage_unit_pkg.sv
// Shared types and sizing for the issue stage: instruction formats, RS/execute packets.
// Consumed by issue_regfile and issue_stage_unit (optional bypass macro: ISSUE_WB_BYPASS_EN).
package issue_stage_unit_pkg;

  localparam int N_WAY     = 3;
  localparam int N_PHY_REG = 64;
  localparam int XLEN      = 32;
  localparam int CDB_BITS  = $clog2(N_PHY_REG);
  localparam int ZR_W      = CDB_BITS + 1;
  localparam int CNT_W     = $clog2(N_WAY) + 1;

  localparam logic [6:0] RV32_OP       = 7'b0110011;
  localparam logic [6:0] RV32_OP_IMM   = 7'b0010011;
  localparam logic [6:0] MD_FUN7       = 7'b0000001;
  localparam logic [2:0] MD_MUL_FUN3    = 3'b000;
  localparam logic [2:0] MD_MULH_FUN3   = 3'b001;
  localparam logic [2:0] MD_MULHSU_FUN3 = 3'b010;
  localparam logic [2:0] MD_MULHU_FUN3  = 3'b011;
  localparam logic [2:0] MD_DIV_FUN3    = 3'b100;
  localparam logic [2:0] MD_DIVU_FUN3   = 3'b101;
  localparam logic [2:0] MD_REM_FUN3    = 3'b110;
  localparam logic [2:0] MD_REMU_FUN3   = 3'b111;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } R_TYPE;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } I_TYPE;

  typedef union packed {
    logic [XLEN-1:0] inst;
    R_TYPE           r;
    I_TYPE           i;
  } INST;

  typedef struct packed {
    logic [CDB_BITS-1:0] source_tag_1;
    logic [CDB_BITS-1:0] source_tag_2;
    logic [CDB_BITS-1:0] dest_tag;
    INST                 inst;
    logic                valid;
  } RS_PACKET_ISSUE;

  typedef struct packed {
    INST                 inst;
    logic [CDB_BITS-1:0] dest_tag;
    logic [XLEN-1:0]     rs1_value;
    logic [XLEN-1:0]     rs2_value;
    logic                valid;
  } ISSUE_EX_PACKET;

  localparam int RS_PKT_W = $bits(RS_PACKET_ISSUE);
  localparam int EX_PKT_W = $bits(ISSUE_EX_PACKET);

  // zero_reg_pr carries one extra bit, so a tag only matches when that bit is clear
  function automatic logic is_zero_pr(logic [CDB_BITS-1:0] tag, logic [ZR_W-1:0] zr);
    return {1'b0, tag} == zr;
  endfunction

endpackage

// File: rtl/issue_stage_unit_regfile.sv
// Physical register file: N_WAY write ports, 2*N_WAY combinational read ports, x0 masking.
// ISSUE_WB_BYPASS_EN forwards same-cycle writeback data to reads (highest way wins).
module issue_regfile
  import issue_stage_unit_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_WAY-1:0]                     wr_en_i,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]       wr_idx_i,
  input  logic [N_WAY-1:0][XLEN-1:0]           wr_data_i,
  input  logic [ZR_W-1:0]                      zero_reg_i,
  input  logic [2*N_WAY-1:0][CDB_BITS-1:0]     rd_tag_i,
  output logic [2*N_WAY-1:0][XLEN-1:0]         rd_data_o
);

  logic [XLEN-1:0] mem_q [N_PHY_REG];

  // Later ways overwrite earlier ones through NBA ordering, so the highest way wins a conflict
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_PHY_REG; i++) mem_q[i] <= '0;
    end else begin
      for (int w = 0; w < N_WAY; w++) begin
        if (wr_en_i[w] && !is_zero_pr(wr_idx_i[w], zero_reg_i)) mem_q[wr_idx_i[w]] <= wr_data_i[w];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int r = 0; r < 2*N_WAY; r++) begin
      rd_data_o[r] = mem_q[rd_tag_i[r]];
`ifdef ISSUE_WB_BYPASS_EN
      for (int w = 0; w < N_WAY; w++) begin
        if (wr_en_i[w] && (wr_idx_i[w] == rd_tag_i[r])) rd_data_o[r] = wr_data_i[w];
      end
`endif
      if (is_zero_pr(rd_tag_i[r], zero_reg_i)) rd_data_o[r] = '0;
    end
  end

endmodule

// File: rtl/issue_stage_unit.sv
// Superscalar issue stage: reads operands for up to N_WAY RS packets and registers them for execute.
// One-cycle latency, never stalls; ISSUE_WB_BYPASS_EN enables writeback-to-read forwarding.
module issue_stage_unit
  import issue_stage_unit_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_WAY*RS_PKT_W-1:0]     rs_packet_issue,
  input  logic [N_WAY-1:0]              wb_reg_wr_en_out,
  input  logic [N_WAY*CDB_BITS-1:0]     wb_reg_wr_idx_out,
  input  logic [N_WAY*XLEN-1:0]         wb_reg_wr_data_out,
  input  logic [ZR_W-1:0]               zero_reg_pr,
  output logic [N_WAY*EX_PKT_W-1:0]     issue_packet,
  output logic [CNT_W-1:0]              count,
  output logic [CNT_W-1:0]              issue_num
);

  RS_PACKET_ISSUE [N_WAY-1:0]       rs;
  ISSUE_EX_PACKET [N_WAY-1:0]       issue_d, issue_q;
  logic [2*N_WAY-1:0][CDB_BITS-1:0] rd_tag;
  logic [2*N_WAY-1:0][XLEN-1:0]     rd_data;

  assign rs = rs_packet_issue;

  always_comb begin
    rd_tag = '0;
    for (int w = 0; w < N_WAY; w++) begin
      rd_tag[2*w]   = rs[w].source_tag_1;
      rd_tag[2*w+1] = rs[w].source_tag_2;
    end
  end

  issue_regfile u_regfile (
    .clock      (clock),
    .reset      (reset),
    .wr_en_i    (wb_reg_wr_en_out),
    .wr_idx_i   (wb_reg_wr_idx_out),
    .wr_data_i  (wb_reg_wr_data_out),
    .zero_reg_i (zero_reg_pr),
    .rd_tag_i   (rd_tag),
    .rd_data_o  (rd_data)
  );

  // Invalid ways are zeroed entirely so downstream never sees stale fields
  always_comb begin
    issue_d = '0;
    for (int w = 0; w < N_WAY; w++) begin
      if (rs[w].valid) begin
        issue_d[w].inst      = rs[w].inst;
        issue_d[w].dest_tag  = rs[w].dest_tag;
        issue_d[w].rs1_value = rd_data[2*w];
        issue_d[w].rs2_value = rd_data[2*w+1];
        issue_d[w].valid     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) issue_q <= '0;
    else        issue_q <= issue_d;
  end

  always_comb begin
    count = '0;
    for (int w = 0; w < N_WAY; w++) count = count + CNT_W'(issue_q[w].valid);
  end

  assign issue_packet = issue_q;
  assign issue_num    = CNT_W'(N_WAY);

endmodule

// File: tb/tb_issue_stage_unit.sv
// Directed bench for issue_stage_unit with a queue of expected issue packets per checked cycle.
module tb_issue_stage_unit;
  import issue_stage_unit_pkg::*;

  typedef struct {
    ISSUE_EX_PACKET pk [N_WAY];
    int             cnt;
  } exp_t;

  logic                          clock = 1'b0;
  logic                          reset;
  RS_PACKET_ISSUE [N_WAY-1:0]    rs_arr;
  logic [N_WAY-1:0]              wb_en;
  logic [N_WAY-1:0][CDB_BITS-1:0] wb_idx;
  logic [N_WAY-1:0][XLEN-1:0]    wb_data;
  logic [ZR_W-1:0]               zero_reg_pr;
  ISSUE_EX_PACKET [N_WAY-1:0]    iss_arr;
  logic [CNT_W-1:0]              count;
  logic [CNT_W-1:0]              issue_num;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [$];

  issue_stage_unit dut (
    .clock              (clock),
    .reset              (reset),
    .rs_packet_issue    (rs_arr),
    .wb_reg_wr_en_out   (wb_en),
    .wb_reg_wr_idx_out  (wb_idx),
    .wb_reg_wr_data_out (wb_data),
    .zero_reg_pr        (zero_reg_pr),
    .issue_packet       (iss_arr),
    .count              (count),
    .issue_num          (issue_num)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic INST mk_m(input logic [2:0] f3, input logic [4:0] rd);
    INST x;
    x.r.funct7 = MD_FUN7; x.r.rs2 = 5'd2; x.r.rs1 = 5'd1;
    x.r.funct3 = f3; x.r.rd = rd; x.r.opcode = RV32_OP;
    return x;
  endfunction

  function automatic INST mk_addi(input logic [11:0] imm, input logic [4:0] rd);
    INST x;
    x.i.imm = imm; x.i.rs1 = 5'd3; x.i.funct3 = 3'b000; x.i.rd = rd; x.i.opcode = RV32_OP_IMM;
    return x;
  endfunction

  function automatic RS_PACKET_ISSUE mk_rs(input int t1, input int t2, input int d, input INST ins, input logic v);
    RS_PACKET_ISSUE p;
    p.source_tag_1 = CDB_BITS'(t1); p.source_tag_2 = CDB_BITS'(t2);
    p.dest_tag = CDB_BITS'(d); p.inst = ins; p.valid = v;
    return p;
  endfunction

  function automatic ISSUE_EX_PACKET mk_ex(input INST ins, input int d, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    ISSUE_EX_PACKET p;
    p.inst = ins; p.dest_tag = CDB_BITS'(d); p.rs1_value = a; p.rs2_value = b; p.valid = 1'b1;
    return p;
  endfunction

  // Expected entry: listed packets in ways 0.., remaining ways all-zero
  task automatic push_exp(input ISSUE_EX_PACKET p0, input ISSUE_EX_PACKET p1, input ISSUE_EX_PACKET p2, input int cnt);
    exp_t e;
    e.pk[0] = p0; e.pk[1] = p1; e.pk[2] = p2; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    rs_arr = '0; wb_en = '0; wb_idx = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clock); #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      for (int w = 0; w < N_WAY; w++)
        chk($sformatf("%s_way%0d", tag, w), 128'(iss_arr[w]), 128'(e.pk[w]));
      chk({tag, "_count"}, 128'(count), 128'(e.cnt));
      chk({tag, "_issue_num"}, 128'(issue_num), 128'(N_WAY));
    end
  endtask

  localparam ISSUE_EX_PACKET NONE = '0;

  initial begin
    INST i0, i1, i2;
    reset = 1'b0;
    zero_reg_pr = 7'd45;
    clear_inputs();

    // Reset held two cycles
    repeat (2) @(posedge clock);
    #1;
    for (int w = 0; w < N_WAY; w++) chk($sformatf("rst_valid%0d", w), 128'(iss_arr[w].valid), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_issue_num", 128'(issue_num), 128'(3));
    reset = 1'b1;
    tick();
    chk("post_rst_count", 128'(count), 128'(0));
    chk("post_rst_pkt", 128'(iss_arr), 128'(0));

    // Load regfile: entry i holds i, entry 45 (x0) left unwritten
    for (int i = 0; i < N_PHY_REG; i++) begin
      wb_en[0] = (i != 45); wb_idx[0] = CDB_BITS'(i); wb_data[0] = XLEN'(i);
      tick();
    end
    clear_inputs();

    i0 = mk_m(MD_MUL_FUN3, 5'd4);
    rs_arr[0] = mk_rs(1, 2, 32, i0, 1'b1);
    push_exp(mk_ex(i0, 32, 1, 2), NONE, NONE, 1);
    tick_check("mul");
    clear_inputs();

    // Writing the zero register is dropped and reads of it return 0
    wb_en[0] = 1'b1; wb_idx[0] = 6'd45; wb_data[0] = 32'd99;
    tick();
    clear_inputs();
    i0 = mk_addi(12'd17, 5'd5);
    rs_arr[0] = mk_rs(45, 44, 36, i0, 1'b1);
    push_exp(mk_ex(i0, 36, 0, 44), NONE, NONE, 1);
    tick_check("zero_reg");
    clear_inputs();

    zero_reg_pr = 7'd44;
    rs_arr[0] = mk_rs(44, 45, 36, i0, 1'b1);
    push_exp(mk_ex(i0, 36, 0, 0), NONE, NONE, 1);
    tick_check("zero_moved");
    clear_inputs();
    zero_reg_pr = 7'd45;

    // Full width, way order preserved
    i0 = mk_m(MD_MULH_FUN3, 5'd6);
    i1 = mk_m(MD_MULHU_FUN3, 5'd7);
    i2 = mk_addi(12'hfff, 5'd8);
    rs_arr[0] = mk_rs(3, 4, 33, i0, 1'b1);
    rs_arr[1] = mk_rs(5, 6, 34, i1, 1'b1);
    rs_arr[2] = mk_rs(7, 8, 35, i2, 1'b1);
    push_exp(mk_ex(i0, 33, 3, 4), mk_ex(i1, 34, 5, 6), mk_ex(i2, 35, 7, 8), 3);
    tick_check("full");
    clear_inputs();

    // Boundary tags 0 and 63
    rs_arr[0] = mk_rs(63, 0, 37, i0, 1'b1);
    rs_arr[1] = mk_rs(62, 61, 38, i1, 1'b1);
    push_exp(mk_ex(i0, 37, 63, 0), mk_ex(i1, 38, 62, 61), NONE, 2);
    tick_check("edge_tags");
    clear_inputs();

    // Partial then idle; invalid ways carry garbage that must not leak
    rs_arr[0] = mk_rs(9, 10, 39, i2, 1'b1);
    rs_arr[1] = mk_rs(11, 12, 40, i1, 1'b0);
    rs_arr[2] = mk_rs(13, 14, 41, i0, 1'b0);
    push_exp(mk_ex(i2, 39, 9, 10), NONE, NONE, 1);
    tick_check("partial");
    rs_arr[0].valid = 1'b0;
    push_exp(NONE, NONE, NONE, 0);
    tick_check("idle");
    clear_inputs();

    // Same-index write conflict plus reads in the writeback cycle
    wb_en = 3'b111;
    wb_idx[0] = 6'd10; wb_data[0] = 32'd5;
    wb_idx[1] = 6'd12; wb_data[1] = 32'd500;
    wb_idx[2] = 6'd10; wb_data[2] = 32'd7;
    i0 = mk_m(MD_MUL_FUN3, 5'd9);
    rs_arr[0] = mk_rs(10, 11, 42, i0, 1'b1);
    rs_arr[1] = mk_rs(45, 12, 43, i1, 1'b1);
`ifdef ISSUE_WB_BYPASS_EN
    push_exp(mk_ex(i0, 42, 7, 11), mk_ex(i1, 43, 0, 500), NONE, 2);
`else
    push_exp(mk_ex(i0, 42, 10, 11), mk_ex(i1, 43, 0, 12), NONE, 2);
`endif
    tick_check("wb_same_cycle");
    clear_inputs();

    rs_arr[0] = mk_rs(10, 12, 44, i0, 1'b1);
    push_exp(mk_ex(i0, 44, 7, 500), NONE, NONE, 1);
    tick_check("wb_after");
    clear_inputs();

    // Asynchronous reset clears issue register and regfile
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", 128'(count), 128'(0));
    chk("async_rst_pkt", 128'(iss_arr), 128'(0));
    @(negedge clock);
    reset = 1'b1;
    rs_arr[0] = mk_rs(10, 63, 45, i0, 1'b1);
    push_exp(mk_ex(i0, 45, 0, 0), NONE, NONE, 1);
    tick_check("rf_cleared");
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
